// File: rtl/regfile_wb_sink.sv
// regfile_wb_sink: WB-stage sink committing byte-lane writes into a 32x32 GPR file,
// two combinational read ports, per-register pending-write scoreboard. Option: RF_BYPASS_EN.
module regfile_wb_sink #(
    parameter int unsigned SB_CNT_W  = 3,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [40:0] ws_to_rf_bus,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    output logic        rbusy1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    output logic        rbusy2,
    input  logic        sb_set,
    input  logic [4:0]  sb_set_addr,
    output logic        sb_ovf
);

    localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);

    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wr_en;

    assign {rf_we, rf_waddr, rf_wdata} = ws_to_rf_bus;
    assign wr_en = (rf_we != '0) && (rf_waddr != '0);

    logic [31:0]         gpr_q [32];
    logic [31:0]         gpr_d [32];
    logic [SB_CNT_W-1:0] cnt_q [32];
    logic [SB_CNT_W-1:0] cnt_d [32];
    logic                ovf_q, ovf_d;
    logic [31:0]         inc_vec, dec_vec;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (sb_set && (sb_set_addr != '0)) inc_vec[sb_set_addr] = 1'b1;
        if (wr_en)                         dec_vec[rf_waddr]    = 1'b1;
    end

    always_comb begin
        gpr_d = gpr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (wr_en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (rf_we[i]) gpr_d[rf_waddr][8*i +: 8] = rf_wdata[8*i +: 8];
            end
        end
        // Simultaneous issue and commit to the same register cancel out.
        for (int unsigned r = 1; r < 32; r++) begin
            if (inc_vec[r] && !dec_vec[r]) begin
                if (cnt_q[r] == CNT_MAX) ovf_d = 1'b1;
                else                     cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec_vec[r] && !inc_vec[r]) begin
                if (cnt_q[r] == '0) ovf_d = 1'b1;
                else                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < 32; r++) begin
                gpr_q[r] <= (r == 0) ? '0 : RESET_VAL;
                cnt_q[r] <= '0;
            end
            ovf_q <= 1'b0;
        end else begin
            gpr_q <= gpr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    logic [4:0]  raddr [2];
    logic [31:0] rdata [2];
    logic        rbusy [2];

    assign raddr[0] = raddr1;
    assign raddr[1] = raddr2;

    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            rdata[p] = '0;
            rbusy[p] = 1'b0;
            if (raddr[p] != '0) begin
                rdata[p] = gpr_q[raddr[p]];
                rbusy[p] = (cnt_q[raddr[p]] != '0);
`ifdef RF_BYPASS_EN
                if (wr_en && (raddr[p] == rf_waddr)) begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        if (rf_we[i]) rdata[p][8*i +: 8] = rf_wdata[8*i +: 8];
                    end
                    if (!inc_vec[raddr[p]] && (cnt_q[raddr[p]] == CNT_ONE)) rbusy[p] = 1'b0;
                end
`endif
            end
        end
    end

    assign rdata1 = rdata[0];
    assign rdata2 = rdata[1];
    assign rbusy1 = rbusy[0];
    assign rbusy2 = rbusy[1];
    assign sb_ovf = ovf_q;

endmodule
